// File: rtl/load_store_unit_if.sv
// Bus bundle between the core execute stage, the load/store unit and the memory responders.
// master: the load/store unit's view; slave: the core/responder side.
interface load_store_unit_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rstrb;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wmask;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rbusy;
    logic              mem_wbusy;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_rdata, mem_rbusy, mem_wbusy,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_rstrb, mem_wdata, mem_wmask
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_rdata, mem_rbusy, mem_wbusy,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_rstrb, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request becomes one word-aligned memory transaction.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses report resp_err instead of being force-aligned.
module load_store_unit (
    input  logic              clk,
    input  logic              resetn,
    load_store_unit_if.master bus
);
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    typedef struct packed {
        logic       we;
        logic [2:0] funct3;
        logic [1:0] off;
        logic       trap;
    } req_t;

    state_t          r_state, w_state_nxt;
    req_t            r_req, w_req_nxt;
    logic [DW-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic            r_mem_rstrb, w_mem_rstrb_nxt;
    logic [DW-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic [3:0]      r_mem_wmask, w_mem_wmask_nxt;
    logic            r_resp_valid, w_resp_valid_nxt;
    logic [DW-1:0]   r_resp_rdata, w_resp_rdata_nxt;
    logic            r_resp_err, w_resp_err_nxt;

    logic            w_is_word, w_is_half, w_misalign, w_busy;
    logic [1:0]      w_off;
    logic [3:0]      w_wmask;
    logic [DW-1:0]   w_wdata_rep, w_shifted, w_load_ext;

    assign w_is_word = bus.req_funct3[1];
    assign w_is_half = (bus.req_funct3[1:0] == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = (w_is_half && bus.req_addr[0]) ||
                        (w_is_word && (bus.req_addr[1:0] != 2'b00));
    assign w_off      = bus.req_addr[1:0];
`else
    assign w_misalign = 1'b0;
    assign w_off      = w_is_word ? 2'b00 :
                        (w_is_half ? {bus.req_addr[1], 1'b0} : bus.req_addr[1:0]);
`endif

    // Byte-lane mask and lane-replicated store data for the incoming request
    always_comb begin
        w_wmask     = 4'b1111;
        w_wdata_rep = bus.req_wdata;
        if (w_is_half) begin
            w_wmask     = 4'(4'b0011 << w_off);
            w_wdata_rep = {2{bus.req_wdata[15:0]}};
        end else if (!w_is_word) begin
            w_wmask     = 4'(4'b0001 << w_off);
            w_wdata_rep = {4{bus.req_wdata[7:0]}};
        end
    end

    // Align the returned word and extend (funct3[2]=1 selects zero extension)
    assign w_shifted = bus.mem_rdata >> {r_req.off, 3'b000};
    always_comb begin
        case (r_req.funct3[1:0])
            2'b00:   w_load_ext = {{24{!r_req.funct3[2] && w_shifted[7]}},  w_shifted[7:0]};
            2'b01:   w_load_ext = {{16{!r_req.funct3[2] && w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

    assign w_busy = r_req.we ? bus.mem_wbusy : bus.mem_rbusy;

    always_comb begin
        w_state_nxt      = r_state;
        w_req_nxt        = r_req;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_rstrb_nxt  = 1'b0;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_mem_wmask_nxt  = 4'b0000;
        w_resp_valid_nxt = 1'b0;
        w_resp_rdata_nxt = r_resp_rdata;
        w_resp_err_nxt   = r_resp_err;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_req_nxt       = '{we: bus.req_we, funct3: bus.req_funct3,
                                        off: w_off, trap: w_misalign};
                    w_mem_addr_nxt  = {bus.req_addr[DW-1:2], 2'b00};
                    w_mem_wdata_nxt = w_wdata_rep;
                    w_mem_rstrb_nxt = !w_misalign && !bus.req_we;
                    w_mem_wmask_nxt = (!w_misalign && bus.req_we) ? w_wmask : 4'b0000;
                    w_state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                // A trapped access never touched the bus, so it completes without waiting
                if (r_req.trap) begin
                    w_resp_valid_nxt = 1'b1;
                    w_resp_err_nxt   = 1'b1;
                    w_resp_rdata_nxt = '0;
                    w_state_nxt      = DONE;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!w_busy) begin
                    w_resp_valid_nxt = 1'b1;
                    w_resp_err_nxt   = 1'b0;
                    w_resp_rdata_nxt = r_req.we ? '0 : w_load_ext;
                    w_state_nxt      = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_req        <= '0;
            r_mem_addr   <= '0;
            r_mem_rstrb  <= 1'b0;
            r_mem_wdata  <= '0;
            r_mem_wmask  <= 4'b0000;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_req        <= w_req_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_rstrb  <= w_mem_rstrb_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_wmask  <= w_mem_wmask_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_resp_err   <= w_resp_err_nxt;
        end
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_rstrb  = r_mem_rstrb;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_wmask  = r_mem_wmask;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; honours LSU_MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;
    logic clk;
    logic resetn;
    int   errors;
    int   checks;

    load_store_unit_if bus ();

    load_store_unit u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled and inputs driven 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        step();
        bus.req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid); end
        checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata got=%h exp=0", bus.resp_rdata); end
        checks++; if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err got=%b exp=0", bus.resp_err); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got=%h exp=0", bus.mem_addr); end
        checks++; if (bus.mem_rstrb !== 1'b0) begin errors++; $display("FAIL rst_rstrb got=%b exp=0", bus.mem_rstrb); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got=%h exp=0", bus.mem_wdata); end
        checks++; if (bus.mem_wmask !== 4'h0) begin errors++; $display("FAIL rst_wmask got=%b exp=0", bus.mem_wmask); end
    endtask

    task automatic test_lw();
        bus.mem_rdata = 32'hDEADBEEF;
        start_req(1'b0, 3'b010, 32'h100, 32'h0);
        checks++; if (bus.mem_rstrb !== 1'b1) begin errors++; $display("FAIL lw_rstrb_issue got=%b exp=1", bus.mem_rstrb); end
        checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL lw_addr got=%h exp=100", bus.mem_addr); end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL lw_ready_busy got=%b exp=0", bus.req_ready); end
        checks++; if (bus.mem_wmask !== 4'h0) begin errors++; $display("FAIL lw_wmask got=%b exp=0", bus.mem_wmask); end
        step();
        checks++; if (bus.mem_rstrb !== 1'b0) begin errors++; $display("FAIL lw_rstrb_wait got=%b exp=0", bus.mem_rstrb); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL lw_early_valid got=%b exp=0", bus.resp_valid); end
        step();
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL lw_valid got=%b exp=1", bus.resp_valid); end
        checks++; if (bus.resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got=%h exp=deadbeef", bus.resp_rdata); end
        checks++; if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL lw_err got=%b exp=0", bus.resp_err); end
        checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL lw_addr_hold got=%h exp=100", bus.mem_addr); end
        step();
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL lw_valid_pulse got=%b exp=0", bus.resp_valid); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL lw_ready_idle got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3_v  [8];
        logic [31:0] adr_v [8];
        logic [31:0] exp_v [8];
        f3_v  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001, 3'b000, 3'b100};
        adr_v = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100, 32'h102, 32'h102};
        exp_v = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF,
                  32'h00000012, 32'h00001234, 32'hFFFFFFFF, 32'h000000FF};
        bus.mem_rdata = 32'h80FF1234;
        for (int i = 0; i < 8; i++) begin
            start_req(1'b0, f3_v[i], adr_v[i], 32'h0);
            step();
            step();
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exp_v[i]) begin
                errors++;
                $display("FAIL load_ext[%0d] got valid=%b data=%h exp valid=1 data=%h",
                         i, bus.resp_valid, bus.resp_rdata, exp_v[i]);
            end
            step();
        end
    endtask

    task automatic test_store();
        logic [2:0]  f3_v  [3];
        logic [31:0] adr_v [3];
        logic [31:0] wd_v  [3];
        logic [3:0]  msk_v [3];
        logic [31:0] rep_v [3];
        f3_v  = '{3'b000, 3'b001, 3'b010};
        adr_v = '{32'h201, 32'h202, 32'h300};
        wd_v  = '{32'h000000A5, 32'h0000BEEF, 32'h12345678};
        msk_v = '{4'b0010, 4'b1100, 4'b1111};
        rep_v = '{32'hA5A5A5A5, 32'hBEEFBEEF, 32'h12345678};
        for (int i = 0; i < 3; i++) begin
            start_req(1'b1, f3_v[i], adr_v[i], wd_v[i]);
            checks++; if (bus.mem_wmask !== msk_v[i]) begin errors++; $display("FAIL st_mask[%0d] got=%b exp=%b", i, bus.mem_wmask, msk_v[i]); end
            checks++; if (bus.mem_wdata !== rep_v[i]) begin errors++; $display("FAIL st_wdata[%0d] got=%h exp=%h", i, bus.mem_wdata, rep_v[i]); end
            checks++; if (bus.mem_addr !== {adr_v[i][31:2], 2'b00}) begin errors++; $display("FAIL st_addr[%0d] got=%h", i, bus.mem_addr); end
            checks++; if (bus.mem_rstrb !== 1'b0) begin errors++; $display("FAIL st_rstrb[%0d] got=%b exp=0", i, bus.mem_rstrb); end
            step();
            checks++; if (bus.mem_wmask !== 4'h0) begin errors++; $display("FAIL st_mask_once[%0d] got=%b exp=0", i, bus.mem_wmask); end
            step();
            checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL st_resp[%0d] got valid=%b data=%h exp 1/0", i, bus.resp_valid, bus.resp_rdata); end
            checks++; if (bus.mem_wdata !== rep_v[i]) begin errors++; $display("FAIL st_wdata_hold[%0d] got=%h exp=%h", i, bus.mem_wdata, rep_v[i]); end
            step();
        end
    endtask

    task automatic test_busy();
        int first;
        // Load with 5 busy WAIT cycles: stale data during busy must not be captured
        bus.mem_rbusy = 1'b1;
        bus.mem_rdata = 32'h11111111;
        start_req(1'b0, 3'b010, 32'h600, 32'h0);
        first = -1;
        for (int k = 2; k <= 20 && first < 0; k++) begin
            step();
            if (bus.resp_valid === 1'b1) first = k;
            if (k == 7) begin
                bus.mem_rbusy = 1'b0;
                bus.mem_rdata = 32'hCAFEF00D;
            end
        end
        checks++; if (first != 8) begin errors++; $display("FAIL lw_busy_latency got=%0d exp=8", first); end
        checks++; if (bus.resp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL lw_busy_rdata got=%h exp=cafef00d", bus.resp_rdata); end
        bus.mem_rbusy = 1'b0;
        step();
        // Store with 2 busy WAIT cycles; mem_rbusy held high must be ignored
        bus.mem_wbusy = 1'b1;
        bus.mem_rbusy = 1'b1;
        start_req(1'b1, 3'b010, 32'h700, 32'h55AA55AA);
        first = -1;
        for (int k = 2; k <= 20 && first < 0; k++) begin
            step();
            if (bus.resp_valid === 1'b1) first = k;
            if (k == 2) begin
                checks++; if (bus.mem_wmask !== 4'h0) begin errors++; $display("FAIL sw_busy_mask got=%b exp=0", bus.mem_wmask); end
            end
            if (k == 4) bus.mem_wbusy = 1'b0;
        end
        checks++; if (first != 5) begin errors++; $display("FAIL sw_busy_latency got=%0d exp=5", first); end
        bus.mem_wbusy = 1'b0;
        bus.mem_rbusy = 1'b0;
        step();
    endtask

    task automatic test_misalign();
        bus.mem_rdata = 32'h80FF1234;
        start_req(1'b0, 3'b010, 32'h102, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (bus.mem_rstrb !== 1'b0) begin errors++; $display("FAIL mis_rstrb got=%b exp=0", bus.mem_rstrb); end
        step();
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1) begin errors++; $display("FAIL mis_trap got valid=%b err=%b exp 1/1", bus.resp_valid, bus.resp_err); end
        checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL mis_rdata got=%h exp=0", bus.resp_rdata); end
        step();
        start_req(1'b1, 3'b001, 32'h203, 32'h0000BEEF);
        checks++; if (bus.mem_wmask !== 4'h0) begin errors++; $display("FAIL mis_sh_mask got=%b exp=0", bus.mem_wmask); end
        step();
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1) begin errors++; $display("FAIL mis_sh_trap got valid=%b err=%b exp 1/1", bus.resp_valid, bus.resp_err); end
        step();
`else
        checks++; if (bus.mem_rstrb !== 1'b1 || bus.mem_addr !== 32'h100) begin errors++; $display("FAIL mis_issue got rstrb=%b addr=%h exp 1/100", bus.mem_rstrb, bus.mem_addr); end
        step();
        step();
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL mis_resp got valid=%b err=%b exp 1/0", bus.resp_valid, bus.resp_err); end
        checks++; if (bus.resp_rdata !== 32'h80FF1234) begin errors++; $display("FAIL mis_rdata got=%h exp=80ff1234", bus.resp_rdata); end
        step();
        start_req(1'b1, 3'b001, 32'h203, 32'h0000BEEF);
        checks++; if (bus.mem_wmask !== 4'b1100) begin errors++; $display("FAIL mis_sh_mask got=%b exp=1100", bus.mem_wmask); end
        step();
        step();
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL mis_sh_resp got valid=%b err=%b exp 1/0", bus.resp_valid, bus.resp_err); end
        step();
`endif
    endtask

    task automatic test_reset_mid();
        int seen;
        start_req(1'b1, 3'b010, 32'h400, 32'hA1B2C3D4);
        checks++; if (bus.mem_wmask !== 4'b1111) begin errors++; $display("FAIL rmid_mask_before got=%b exp=1111", bus.mem_wmask); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (bus.mem_wmask !== 4'h0) begin errors++; $display("FAIL rmid_mask got=%b exp=0", bus.mem_wmask); end
        checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rmid_bus got addr=%h wdata=%h exp 0/0", bus.mem_addr, bus.mem_wdata); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b exp=1", bus.req_ready); end
        step();
        step();
        resetn = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus.resp_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rmid_no_resp got=%0d exp=0", seen); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_after got=%b exp=1", bus.req_ready); end
        bus.mem_rdata = 32'h0BADF00D;
        start_req(1'b0, 3'b010, 32'h500, 32'h0);
        step();
        step();
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL rmid_next got valid=%b data=%h exp 1/0badf00d", bus.resp_valid, bus.resp_rdata); end
        step();
    endtask

    task automatic test_back_to_back();
        bus.mem_rdata  = 32'h01020304;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h800;
        bus.req_wdata  = 32'h0;
        step();
        step();
        step();
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b exp=1", bus.resp_valid); end
        step();
        checks++; if (bus.req_ready !== 1'b1 || bus.mem_rstrb !== 1'b0) begin errors++; $display("FAIL b2b_idle got ready=%b rstrb=%b exp 1/0", bus.req_ready, bus.mem_rstrb); end
        step();
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_rstrb !== 1'b1 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_second got rstrb=%b ready=%b exp 1/0", bus.mem_rstrb, bus.req_ready); end
        step();
        step();
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h01020304) begin errors++; $display("FAIL b2b_resp got valid=%b data=%h exp 1/01020304", bus.resp_valid, bus.resp_rdata); end
        step();
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        resetn         = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.mem_rdata  = 32'h0;
        bus.mem_rbusy  = 1'b0;
        bus.mem_wbusy  = 1'b0;
        step();
        step();
        test_reset();
        resetn = 1'b1;
        step();
        test_lw();
        test_load_ext();
        test_store();
        test_busy();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
